// File: rtl/v_duty_decoder.sv
// Receive-side V_Duty checker: measures the first pulse per frame (high width and trailing
// low width), classifies it as none/AVG/MAX/unknown and publishes the results on each iVSYNC rise.
module v_duty_decoder #(
  parameter int CNT_W  = 18,
  parameter int AVG_ON = 140520,
  parameter int MAX_ON = 158120,
  parameter int TOL    = 8
) (
  input  logic             iODCK,
  input  logic             iRST,
  input  logic             iVSYNC,
  input  logic             iV_Duty,
  output logic [CNT_W-1:0] oOnCnt,
  output logic [CNT_W-1:0] oOffCnt,
  output logic [1:0]       oMode,
  output logic             oErr,
  output logic             oValid
);

  typedef enum logic [2:0] {IDLE, WAIT, ON, OFF, HOLD} state_t;

  localparam logic [CNT_W-1:0]        CNT_MAX = '1;
  localparam logic signed [CNT_W:0]   AVG_S   = (CNT_W+1)'(AVG_ON);
  localparam logic signed [CNT_W:0]   MAX_S   = (CNT_W+1)'(MAX_ON);
  localparam logic signed [CNT_W:0]   TOL_S   = (CNT_W+1)'(TOL);

  state_t           state, stateNxt;
  logic             vsD, dutyD;
  logic [CNT_W-1:0] onCnt, offCnt, onNxt, offNxt;
  logic             multi, ovf, multiNxt, ovfNxt;
  logic             frameEdge, rise, publish;
  logic signed [CNT_W:0] avgDiff, maxDiff;
  logic             avgHit, maxHit;
  logic [1:0]       modeCls;

  assign frameEdge = iVSYNC & ~vsD;
  assign rise      = iV_Duty & ~dutyD;

  // Signed one-bit-wider difference keeps the tolerance window symmetric around the target.
  assign avgDiff = $signed({1'b0, onCnt}) - AVG_S;
  assign maxDiff = $signed({1'b0, onCnt}) - MAX_S;
  assign avgHit  = (avgDiff <= TOL_S) && (avgDiff >= -TOL_S);
  assign maxHit  = (maxDiff <= TOL_S) && (maxDiff >= -TOL_S);

  always_comb begin
    modeCls = 2'b11;
    if (state == WAIT)  modeCls = 2'b00;
    else if (avgHit)    modeCls = 2'b01;
    else if (maxHit)    modeCls = 2'b10;
  end

  always_comb begin
    stateNxt = state;
    onNxt    = onCnt;
    offNxt   = offCnt;
    multiNxt = multi;
    ovfNxt   = ovf;
    publish  = 1'b0;
    case (state)
      IDLE: if (frameEdge) stateNxt = WAIT;
      WAIT: if (rise) begin
        stateNxt = ON;
        onNxt    = CNT_W'(1);
      end
      ON: begin
        if (iV_Duty) begin
          if (onCnt == CNT_MAX) ovfNxt = 1'b1;
          else                  onNxt  = onCnt + 1'b1;
        end else begin
          stateNxt = OFF;
          offNxt   = CNT_W'(1);
        end
      end
      OFF: begin
        if (rise) begin
          stateNxt = HOLD;
          multiNxt = 1'b1;
        end else if (offCnt == CNT_MAX) ovfNxt = 1'b1;
        else                            offNxt = offCnt + 1'b1;
      end
      default: ;
    endcase
    // Frame boundary overrides the per-state update; a coincident rise opens the new frame in ON.
    if (frameEdge && state != IDLE) begin
      publish  = 1'b1;
      multiNxt = 1'b0;
      ovfNxt   = 1'b0;
      offNxt   = '0;
      if (rise) begin
        stateNxt = ON;
        onNxt    = CNT_W'(1);
      end else begin
        stateNxt = WAIT;
        onNxt    = '0;
      end
    end
  end

  always_ff @(posedge iODCK) begin
    if (iRST) begin
      state   <= IDLE;
      vsD     <= 1'b0;
      dutyD   <= 1'b0;
      onCnt   <= '0;
      offCnt  <= '0;
      multi   <= 1'b0;
      ovf     <= 1'b0;
      oOnCnt  <= '0;
      oOffCnt <= '0;
      oMode   <= 2'b00;
      oErr    <= 1'b0;
      oValid  <= 1'b0;
    end else begin
      state  <= stateNxt;
      vsD    <= iVSYNC;
      dutyD  <= iV_Duty;
      onCnt  <= onNxt;
      offCnt <= offNxt;
      multi  <= multiNxt;
      ovf    <= ovfNxt;
      oValid <= publish;
      if (publish) begin
        oOnCnt  <= onCnt;
        oOffCnt <= offCnt;
        oMode   <= modeCls;
        oErr    <= multi | ovf | (state == ON);
      end
    end
  end

endmodule

// File: tb/tb_v_duty_decoder.sv
// Randomized bench for v_duty_decoder: two instances (wide, and narrow for saturation)
// checked against a frame-level model that analyses each frame's sampled duty sequence.
module tb_v_duty_decoder;

  logic gclk = 1'b0;
  always #5 gclk = ~gclk;

  logic iRST, iVSYNC, iV_Duty;
  logic [9:0] onA, offA;
  logic [3:0] onB, offB;
  logic [1:0] modeA, modeB;
  logic errA, errB, vldA, vldB;

  v_duty_decoder #(.CNT_W(10), .AVG_ON(140), .MAX_ON(158), .TOL(8)) dutA (
    .iODCK(gclk), .iRST(iRST), .iVSYNC(iVSYNC), .iV_Duty(iV_Duty),
    .oOnCnt(onA), .oOffCnt(offA), .oMode(modeA), .oErr(errA), .oValid(vldA));

  v_duty_decoder #(.CNT_W(4), .AVG_ON(6), .MAX_ON(12), .TOL(1)) dutB (
    .iODCK(gclk), .iRST(iRST), .iVSYNC(iVSYNC), .iV_Duty(iV_Duty),
    .oOnCnt(onB), .oOffCnt(offB), .oMode(modeB), .oErr(errB), .oValid(vldB));

  int W [2] = '{10, 4};
  int AV[2] = '{140, 6};
  int MX[2] = '{158, 12};
  int TL[2] = '{8, 1};

  int nTests = 0, nFail = 0, cyc = 0;
  int expOn[2], expOff[2], expMode[2], expErr[2];

  bit open, pv, pd, fprev;
  bit q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    if (obs !== exp) begin
      nFail++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [31:0] obsV(int k, int f);
    case (f)
      0: return (k == 0) ? 32'(vldA)  : 32'(vldB);
      1: return (k == 0) ? 32'(onA)   : 32'(onB);
      2: return (k == 0) ? 32'(offA)  : 32'(offB);
      3: return (k == 0) ? 32'(modeA) : 32'(modeB);
      default: return (k == 0) ? 32'(errA) : 32'(errB);
    endcase
  endfunction

  task automatic chkAll(input string tag, input bit vExp);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s.vld%0d", tag, k), obsV(k, 0), 32'(vExp));
      chk($sformatf("%s.on%0d", tag, k), obsV(k, 1), expOn[k]);
      chk($sformatf("%s.off%0d", tag, k), obsV(k, 2), expOff[k]);
      chk($sformatf("%s.mode%0d", tag, k), obsV(k, 3), expMode[k]);
      chk($sformatf("%s.err%0d", tag, k), obsV(k, 4), expErr[k]);
    end
  endtask

  // First rising edge of the frame, its high run, then the low run until a second rise or frame end.
  task automatic evalFrame(input bit prev, output bit has, output int on, output int off,
                           output bit trunc, output bit multi);
    int i, n;
    bit p;
    i = 0; n = q.size(); p = prev;
    has = 0; on = 0; off = 0; trunc = 0; multi = 0;
    while (i < n && !(q[i] && !p)) begin p = q[i]; i++; end
    if (i == n) return;
    has = 1;
    while (i < n && q[i]) begin on++; i++; end
    if (i == n) begin trunc = 1; return; end
    while (i < n && !q[i]) begin off++; i++; end
    if (i < n) multi = 1;
  endtask

  task automatic tick(input bit r, input bit v, input bit d);
    bit f, has, tr, mu;
    int on, off, mx, onS, offS, dA, dM;
    f = v & ~pv;
    if (!r && f && open) evalFrame(fprev, has, on, off, tr, mu);
    iRST = r; iVSYNC = v; iV_Duty = d;
    @(posedge gclk); #1;
    cyc++;
    if (r) begin
      open = 0; pv = 0; pd = 0;
      for (int k = 0; k < 2; k++) begin
        expOn[k] = 0; expOff[k] = 0; expMode[k] = 0; expErr[k] = 0;
      end
      chkAll("rst", 1'b0);
      return;
    end
    if (f && open) begin
      for (int k = 0; k < 2; k++) begin
        mx = (1 << W[k]) - 1;
        onS  = (on > mx) ? mx : on;
        offS = (off > mx) ? mx : off;
        dA = (onS > AV[k]) ? onS - AV[k] : AV[k] - onS;
        dM = (onS > MX[k]) ? onS - MX[k] : MX[k] - onS;
        expOn[k]   = has ? onS : 0;
        expOff[k]  = has ? offS : 0;
        expMode[k] = !has ? 0 : (dA <= TL[k]) ? 1 : (dM <= TL[k]) ? 2 : 3;
        expErr[k]  = has && (mu || tr || on > mx || off > mx);
      end
      chkAll("pub", 1'b1);
    end else if (cyc % 32 == 0 || f) begin
      chkAll("hold", 1'b0);
    end else begin
      chk("vldA", 32'(vldA), 0);
      chk("vldB", 32'(vldB), 0);
    end
    if (f) begin
      fprev = open ? pd : 1'b1;  // first edge after reset only arms; a coincident rise is not a pulse
      open = 1;
      q.delete();
      q.push_back(d);
    end else if (open) q.push_back(d);
    pv = v; pd = d;
  endtask

  task automatic frame(input int lead, input int h1, input int l1, input int h2, input int tail);
    bit s[$];
    int vh;
    repeat (lead) s.push_back(1'b0);
    repeat (h1)   s.push_back(1'b1);
    repeat (l1)   s.push_back(1'b0);
    repeat (h2)   s.push_back(1'b1);
    repeat (tail) s.push_back(1'b0);
    while (s.size() < 2) s.push_back(1'b0);
    vh = (s.size() > 3) ? 3 : s.size() - 1;
    foreach (s[i]) tick(1'b0, i < vh, s[i]);
  endtask

  initial begin
    int sel, h1;
    open = 0; pv = 0; pd = 0; fprev = 0;
    iRST = 1; iVSYNC = 1; iV_Duty = 0;
    repeat (3) tick(1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);            // vsync already high at release: arms only
    repeat (4) tick(1'b0, 1'b0, 1'b0);
    frame(2, 140, 17, 0, 0);           // AVG
    frame(2, 163, 3, 0, 0);            // MAX within tolerance
    frame(20, 0, 0, 0, 0);             // no pulse
    frame(2, 100, 50, 20, 5);          // two pulses
    frame(2, 140, 10, 0, 0);           // clean AVG clears err
    frame(2, 158, 10, 0, 0);           // MAX, ends low
    frame(0, 140, 5, 0, 0);            // rise coincides with frame edge
    frame(3, 30, 0, 0, 0);             // pulse runs into frame edge (truncated)
    frame(4, 20, 6, 0, 0);             // saturates narrow instance
    frame(2, 50, 0, 0, 0);             // truncated, stays high across edge
    frame(0, 12, 8, 0, 0);             // continuing high is not a rise
    frame(2, 7, 4, 0, 0);
    // reset mid-pulse
    tick(1'b0, 1'b1, 1'b0);
    repeat (10) tick(1'b0, 1'b0, 1'b1);
    repeat (2) tick(1'b1, 1'b0, 1'b1);
    repeat (5) tick(1'b0, 1'b0, 1'b1);
    frame(2, 6, 3, 0, 0);              // first edge after reset: arms only
    frame(2, 12, 3, 0, 0);
    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0: h1 = $urandom_range(0, 20);
        1: h1 = $urandom_range(130, 150);
        2: h1 = $urandom_range(148, 168);
        default: h1 = $urandom_range(0, 14);
      endcase
      frame($urandom_range(0, 5), h1, $urandom_range(0, 30),
            ($urandom_range(0, 3) == 0) ? $urandom_range(1, 10) : 0, $urandom_range(0, 4));
    end
    tick(1'b0, 1'b1, 1'b0);
    repeat (3) tick(1'b0, 1'b0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
